// File: rtl/systolic_sequencer.sv
// Systolic array sequencer: shifts buffered weights into the array, then
// streams a batch of activation reads and waits for the array to drain.
// Optional feature: define SYSTOLIC_SEQ_PERF_EN to add the perf_cycles
// output, which counts FEED+DRAIN+DONE cycles of the most recent run.
module systolic_sequencer (
   input  logic        clk,
   input  logic        resetn,
   input  logic        weight_transfer,
   input  logic        systolic_start,
   input  logic [4:0]  last_row,
   input  logic [4:0]  last_col,
   input  logic [10:0] activations_addr_start,
   input  logic [5:0]  batch,
   output logic        weight_shift,
   output logic        act_rd_en,
   output logic [10:0] act_rd_addr,
   output logic [31:0] row_mask,
   output logic [31:0] col_mask,
   output logic        busy,
   output logic        done
`ifdef SYSTOLIC_SEQ_PERF_EN
   ,
   output logic [31:0] perf_cycles
`endif
);

   typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, DONE} state_t;

   state_t      state_reg, state_next;
   logic [5:0]  cnt_reg;
   logic        pending_reg;
   logic [4:0]  lr_reg, lc_reg;
   logic [10:0] addr_reg;
   logic [31:0] row_mask_reg, col_mask_reg;
   logic [31:0] row_mask_in, col_mask_in;
   logic [5:0]  drain_in, drain_reg;
   logic        wload, launch;

   // Thermometer masks from the live config inputs, captured only on latch.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_mask
         assign row_mask_in[gi] = (5'(gi) <= last_row);
         assign col_mask_in[gi] = (5'(gi) <= last_col);
      end
   endgenerate

   // Drain length minus one, for a run launched now or one already latched.
   assign drain_in  = {1'b0, last_row} + {1'b0, last_col} + 6'd1;
   assign drain_reg = {1'b0, lr_reg} + {1'b0, lc_reg} + 6'd1;

   // Next-state logic; requests are only honoured from IDLE or via pending.
   always_comb begin
      state_next = state_reg;
      wload      = 1'b0;
      launch     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (weight_transfer) begin
               wload      = 1'b1;
               state_next = LOAD_W;
            end else if (systolic_start) begin
               launch     = 1'b1;
               state_next = (batch == 6'd0) ? DRAIN : FEED;
            end
         end
         LOAD_W: begin
            if (cnt_reg == 6'd0) begin
               if (pending_reg) begin
                  launch     = 1'b1;
                  state_next = (batch == 6'd0) ? DRAIN : FEED;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         FEED:    if (cnt_reg == 6'd0) state_next = DRAIN;
         DRAIN:   if (cnt_reg == 6'd0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State, phase counter, latched config and read address.
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         pending_reg  <= 1'b0;
         lr_reg       <= '0;
         lc_reg       <= '0;
         addr_reg     <= '0;
         row_mask_reg <= '0;
         col_mask_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (wload) begin
            cnt_reg      <= {1'b0, last_row};
            lr_reg       <= last_row;
            row_mask_reg <= row_mask_in;
            pending_reg  <= systolic_start;
         end else if (launch) begin
            pending_reg  <= 1'b0;
            lr_reg       <= last_row;
            lc_reg       <= last_col;
            row_mask_reg <= row_mask_in;
            col_mask_reg <= col_mask_in;
            if (batch != 6'd0) begin
               addr_reg <= activations_addr_start;
               cnt_reg  <= batch - 6'd1;
            end else begin
               cnt_reg  <= drain_in;
            end
         end else begin
            case (state_reg)
               FEED: begin
                  if (cnt_reg == 6'd0) begin
                     cnt_reg <= drain_reg;
                  end else begin
                     cnt_reg  <= cnt_reg - 6'd1;
                     addr_reg <= addr_reg + 11'd1;
                  end
               end
               LOAD_W, DRAIN: if (cnt_reg != 6'd0) cnt_reg <= cnt_reg - 6'd1;
               default: ;
            endcase
         end
      end
   end

`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [31:0] perf_reg;

   // Count run cycles from launch until DONE, saturating; hold while idle.
   always_ff @(posedge clk) begin
      if (resetn) begin
         perf_reg <= '0;
      end else if (launch) begin
         perf_reg <= '0;
      end else if ((state_reg == FEED || state_reg == DRAIN || state_reg == DONE) &&
                   perf_reg != 32'hFFFF_FFFF) begin
         perf_reg <= perf_reg + 32'd1;
      end
   end

   assign perf_cycles = perf_reg;
`endif

   assign weight_shift = (state_reg == LOAD_W);
   assign act_rd_en    = (state_reg == FEED);
   assign act_rd_addr  = addr_reg;
   assign row_mask     = row_mask_reg;
   assign col_mask     = col_mask_reg;
   assign busy         = (state_reg != IDLE);
   assign done         = (state_reg == DONE);

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed and randomized jobs checked against a timeline model of the
// sequencer computed from phase lengths.
module tb_systolic_sequencer;
   logic        clk = 1'b0;
   logic        resetn, weight_transfer, systolic_start;
   logic [4:0]  last_row, last_col;
   logic [10:0] activations_addr_start;
   logic [5:0]  batch;
   logic        weight_shift, act_rd_en, busy, done;
   logic [10:0] act_rd_addr;
   logic [31:0] row_mask, col_mask;
`ifdef SYSTOLIC_SEQ_PERF_EN
   logic [31:0] perf_cycles;
`endif

   int tests = 0;
   int fails = 0;
   logic [10:0] m_addr;
   logic [31:0] m_row, m_col;

   always #5 clk = ~clk;

   systolic_sequencer dut (
      .clk(clk), .resetn(resetn), .weight_transfer(weight_transfer),
      .systolic_start(systolic_start), .last_row(last_row), .last_col(last_col),
      .activations_addr_start(activations_addr_start), .batch(batch),
      .weight_shift(weight_shift), .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr),
      .row_mask(row_mask), .col_mask(col_mask), .busy(busy), .done(done)
`ifdef SYSTOLIC_SEQ_PERF_EN
      , .perf_cycles(perf_cycles)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mask_of(input int n);
      logic [31:0] m;
      for (int i = 0; i < 32; i++) m[i] = (i <= n);
      return m;
   endfunction

   // One job: request at cycle 0, then check every cycle until back in IDLE.
   task automatic run_job(input bit wt, input bit st, input int lr, input int lc,
                          input int a, input int n, input bit noise);
      int L, D, F0, total;
      L     = wt ? lr + 1 : 0;
      D     = lr + lc + 2;
      F0    = L + 1;
      total = L + (st ? n + D + 1 : 0);
      weight_transfer = wt; systolic_start = st;
      last_row = 5'(lr); last_col = 5'(lc);
      activations_addr_start = 11'(a); batch = 6'(n);
      if (wt) m_row = mask_of(lr);
      if (st) begin m_row = mask_of(lr); m_col = mask_of(lc); end
      for (int j = 1; j <= total + 1; j++) begin
         bit e_ws, e_en, e_busy, e_done;
         @(negedge clk);
         e_ws   = (j <= L);
         e_en   = st && (j >= F0) && (j < F0 + n);
         e_done = st && (j == total);
         e_busy = (j <= total);
         if (e_en) m_addr = 11'(a + (j - F0));
         chk("weight_shift", 32'(weight_shift), 32'(e_ws));
         chk("act_rd_en", 32'(act_rd_en), 32'(e_en));
         chk("act_rd_addr", 32'(act_rd_addr), 32'(m_addr));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("done", 32'(done), 32'(e_done));
         if (noise && j <= total) begin
            weight_transfer = 1'($urandom_range(0, 1));
            systolic_start  = 1'($urandom_range(0, 1));
            if (!(wt && st)) begin
               last_row = 5'($urandom); last_col = 5'($urandom);
               activations_addr_start = 11'($urandom); batch = 6'($urandom);
            end
         end else begin
            weight_transfer = 1'b0; systolic_start = 1'b0;
         end
      end
      chk("row_mask", row_mask, m_row);
      chk("col_mask", col_mask, m_col);
`ifdef SYSTOLIC_SEQ_PERF_EN
      if (st) chk("perf_cycles", perf_cycles, 32'(n + D + 1));
`endif
      $display("[TB] job wt=%0d st=%0d lr=%0d lc=%0d addr=%h n=%0d cycles=%0d",
               wt, st, lr, lc, a, n, total);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_ws"}, 32'(weight_shift), 32'd0);
      chk({tag, "_en"}, 32'(act_rd_en), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_addr"}, 32'(act_rd_addr), 32'd0);
      chk({tag, "_row"}, row_mask, 32'd0);
      chk({tag, "_col"}, col_mask, 32'd0);
`ifdef SYSTOLIC_SEQ_PERF_EN
      chk({tag, "_perf"}, perf_cycles, 32'd0);
`endif
   endtask

   initial begin
      resetn = 1'b1; weight_transfer = 1'b0; systolic_start = 1'b0;
      last_row = '0; last_col = '0; activations_addr_start = '0; batch = '0;
      m_addr = '0; m_row = '0; m_col = '0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      resetn = 1'b0;
      @(negedge clk);

      run_job(1'b0, 1'b1, 3, 2, 'h7FE, 4, 1'b0);   // address wrap, 12-cycle run
      run_job(1'b1, 1'b0, 31, 0, 0, 0, 1'b1);      // 32 weight shifts, full row mask
      run_job(1'b1, 1'b1, 1, 3, 'h100, 2, 1'b0);   // pending start after load
      run_job(1'b0, 1'b1, 0, 0, 'h055, 0, 1'b1);   // empty batch
      for (int k = 0; k < 10; k++) begin
         bit wt, st;
         wt = 1'($urandom_range(0, 1));
         st = wt ? 1'($urandom_range(0, 1)) : 1'b1;
         run_job(wt, st, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 int'($urandom_range(0, 2047)), int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of FEED, with a start presented alongside it.
      last_row = 5'd2; last_col = 5'd1; activations_addr_start = 11'd5; batch = 6'd10;
      systolic_start = 1'b1;
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk);
         systolic_start = 1'b0;
         chk("pre_reset_en", 32'(act_rd_en), 32'd1);
      end
      resetn = 1'b1; systolic_start = 1'b1;
      @(negedge clk);
      chk_all_zero("midrun_reset");
      resetn = 1'b0; systolic_start = 1'b0;
      @(negedge clk);
      chk("dropped_start_busy", 32'(busy), 32'd0);
      $display("[TB] mid-run reset applied");
      m_addr = '0; m_row = '0; m_col = '0;
      run_job(1'b0, 1'b1, 4, 5, 'h3FF, 3, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: clk (rising edge) and resetn (active-high, synchronous, despite the name).
REQ-002 clk  input  1  system clock.
REQ-003 resetn  input  1  synchronous active-high reset.
REQ-004 weight_transfer  input  1  one-cycle request to shift buffered weights into the array.
REQ-005 systolic_start  input  1  one-cycle request to run a batch.
REQ-006 last_row  input  5  index of last active array row.
REQ-007 last_col  input  5  index of last active array column.
REQ-008 activations_addr_start  input  11  first activation-buffer read address.
REQ-009 batch  input  6  number of activation vectors to feed; 0 means none.
REQ-010 weight_shift  output  1  weight shift enable into the array.
REQ-011 act_rd_en  output  1  activation-buffer read enable.
REQ-012 act_rd_addr  output  11  activation-buffer read address.
REQ-013 row_mask  output  32  bit i = 1 iff i <= latched last_row.
REQ-014 col_mask  output  32  bit i = 1 iff i <= latched last_col.
REQ-015 busy  output  1  high whenever state != IDLE.
REQ-016 done  output  1  one-cycle pulse at the end of a batch run.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_W, FEED, DRAIN, DONE; all outputs are registered or decoded from registered state only.
REQ-018 In IDLE, weight_transfer=1 at cycle T SHALL enter LOAD_W at T+1 and latch last_row; weight_shift SHALL be high for exactly last_row+1 cycles (T+1..T+last_row+1), then return to IDLE.
REQ-019 In IDLE, systolic_start=1 (weight_transfer=0) at cycle T SHALL latch last_row, last_col, activations_addr_start, and batch (N), and enter FEED at T+1; if N=0, it SHALL enter DRAIN at T+1 instead.
REQ-020 FEED SHALL last N cycles with act_rd_en=1 and act_rd_addr = start+k for k=0..N-1, modulo 2048 (11-bit wrap, 0x7FF -> 0x000).
REQ-021 DRAIN SHALL last last_row+last_col+2 cycles with act_rd_en=0, then enter DONE.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 If weight_transfer and systolic_start are both high in IDLE, weight load SHALL run first; the start SHALL be held in a pending flag and launched (config latched) on the cycle LOAD_W exits, with no IDLE cycle between.
REQ-024 weight_transfer and systolic_start SHALL be ignored while busy=1, except for REQ-023.
REQ-025 row_mask and col_mask SHALL update only when config is latched and hold otherwise; changes to the config inputs during a run SHALL have no effect.
REQ-026 act_rd_addr SHALL hold its last value when act_rd_en=0.

Reset
REQ-027 With resetn=1 at a clock edge, the next cycle SHALL have state=IDLE, pending=0, and all outputs 0, including mid-run; a request seen with resetn=1 SHALL be dropped.

Configuration
REQ-028 With SYSTOLIC_SEQ_PERF_EN defined, the module SHALL add an output perf_cycles (32 bits) that counts cycles spent in FEED+DRAIN+DONE of the most recent run; it is cleared on entering FEED, saturates at 0xFFFFFFFF, holds in IDLE, and resets to 0.
REQ-029 Without SYSTOLIC_SEQ_PERF_EN, the perf_cycles port and counter SHALL be absent, with all other behaviour identical.

Verification
REQ-030 Bench: start=0x7FE, batch=4, last_row=3, last_col=2, start at T -> act_rd_en T+1..T+4 with addresses 0x7FE, 0x7FF, 0x000, 0x001; DRAIN T+5..T+11; done at T+12; busy T+1..T+12.
REQ-031 Bench: weight_transfer with last_row=31 -> weight_shift high for 32 cycles, and row_mask=0xFFFFFFFF.
REQ-032 Bench: weight_transfer and systolic_start in the same cycle, last_row=1, batch=2 -> 2 weight_shift cycles, then FEED immediately for 2 cycles.
REQ-033 Bench: batch=0, last_row=0, last_col=0 -> no act_rd_en, 2 DRAIN cycles, done at T+3.
REQ-034 Bench: resetn pulsed during FEED -> IDLE next cycle, all outputs 0; a start issued during busy is ignored; with SYSTOLIC_SEQ_PERF_EN, REQ-030 run gives perf_cycles=12.
